// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection,
// flush and valid/ready handshaking toward the ALU stage.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_ctl,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic [1:0]  in_use,
  input  logic [15:0] in_rs_data,
  input  logic [15:0] in_rt_data,
  input  logic [2:0]  in_rd,
  input  logic        in_wen,
  input  logic        fw1_wen,
  input  logic        fw1_load,
  input  logic [2:0]  fw1_rd,
  input  logic [15:0] fw1_data,
  input  logic        fw2_wen,
  input  logic [2:0]  fw2_rd,
  input  logic [15:0] fw2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_A,
  output logic [15:0] out_B,
  output logic [6:0]  out_ctl,
  output logic [2:0]  out_rd,
  output logic        out_wen,
  output logic        out_err
);

  // Source slot 1 is operand A (rs), slot 0 is operand B (rt), matching in_use bits.
  logic [1:0][2:0]  src_num;
  logic [1:0][15:0] src_data;
  logic [1:0][15:0] opnd;
  logic [1:0]       load_hit;
  logic             hazard;
  logic             advance;
  logic             capture;
  logic             err_next;

  logic        valid_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [6:0]  ctl_reg;
  logic [2:0]  rd_reg;
  logic        wen_reg;
  logic        err_reg;

  assign src_num  = {in_rs, in_rt};
  assign src_data = {in_rs_data, in_rt_data};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic fw1_hit;
      logic fw2_hit;
      assign fw1_hit      = in_use[gi] & fw1_wen & (fw1_rd == src_num[gi]);
      assign fw2_hit      = in_use[gi] & fw2_wen & (fw2_rd == src_num[gi]);
      assign load_hit[gi] = fw1_hit & fw1_load;
      // A load in EX/MEM has no data yet, so it never wins the forward mux.
      assign opnd[gi] = (fw1_hit & ~fw1_load) ? fw1_data :
                        fw2_hit               ? fw2_data : src_data[gi];
    end
  endgenerate

  assign hazard   = in_valid & (|load_hit);
  assign advance  = ~valid_reg | out_ready;
  assign capture  = advance & in_valid & ~hazard;
  assign in_ready = ~rst & (flush | (advance & ~hazard));
  assign err_next = (in_ctl[6:3] > 4'b1000);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      a_reg     <= 16'h0000;
      b_reg     <= 16'h0000;
      ctl_reg   <= 7'h00;
      rd_reg    <= 3'b000;
      wen_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      wen_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else if (advance) begin
      if (capture) begin
        valid_reg <= 1'b1;
        a_reg     <= opnd[1];
        b_reg     <= opnd[0];
        ctl_reg   <= in_ctl;
        rd_reg    <= in_rd;
        wen_reg   <= in_wen;
        err_reg   <= err_next;
      end else begin
        valid_reg <= 1'b0;
        wen_reg   <= 1'b0;
        err_reg   <= 1'b0;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_A     = a_reg;
  assign out_B     = b_reg;
  assign out_ctl   = ctl_reg;
  assign out_rd    = rd_reg;
  assign out_wen   = wen_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected entries, a
// separate monitor pops and compares whenever the ALU side consumes one.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, in_wen;
  logic [6:0]  in_ctl;
  logic [2:0]  in_rs, in_rt, in_rd;
  logic [1:0]  in_use;
  logic [15:0] in_rs_data, in_rt_data;
  logic        fw1_wen, fw1_load, fw2_wen;
  logic [2:0]  fw1_rd, fw2_rd;
  logic [15:0] fw1_data, fw2_data;
  logic        out_valid, out_ready, out_wen, out_err;
  logic [15:0] out_A, out_B;
  logic [6:0]  out_ctl;
  logic [2:0]  out_rd;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctl(in_ctl), .in_rs(in_rs), .in_rt(in_rt), .in_use(in_use),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_rd(in_rd), .in_wen(in_wen),
    .fw1_wen(fw1_wen), .fw1_load(fw1_load), .fw1_rd(fw1_rd), .fw1_data(fw1_data),
    .fw2_wen(fw2_wen), .fw2_rd(fw2_rd), .fw2_data(fw2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
    .out_ctl(out_ctl), .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [6:0]  ctl;
    logic [2:0]  rd;
    logic        wen;
    logic        err;
  } entry_t;

  entry_t exp_q[$];
  int     checks = 0;
  int     fails = 0;
  bit     model_occ = 1'b0;
  bit     model_known = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference operand choice: youngest non-load producer, then writeback, then regfile.
  function automatic logic [15:0] pick(input bit used, input logic [2:0] r, input logic [15:0] rf);
    if (!used) return rf;
    if (fw1_wen && !fw1_load && fw1_rd == r) return fw1_data;
    if (fw2_wen && fw2_rd == r) return fw2_data;
    return rf;
  endfunction

  function automatic entry_t expected_entry();
    entry_t e;
    e.a   = pick(in_use[1], in_rs, in_rs_data);
    e.b   = pick(in_use[0], in_rt, in_rt_data);
    e.ctl = in_ctl;
    e.rd  = in_rd;
    e.wen = in_wen;
    e.err = (int'(in_ctl[6:3]) > 8);
    return e;
  endfunction

  // Inputs are set by the caller just after a rising edge; this evaluates the
  // model at the falling edge and then waits through the next rising edge.
  task automatic step();
    bit hz, acc, exp_ready;
    @(negedge clk);
    hz = in_valid && fw1_wen && fw1_load &&
         ((in_use[1] && in_rs == fw1_rd) || (in_use[0] && in_rt == fw1_rd));
    exp_ready = !rst && (flush || ((!model_occ || out_ready) && !hz));
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    if (model_known) check("out_valid", 64'(out_valid), 64'(model_occ));
    acc = !rst && !flush && (!model_occ || out_ready) && in_valid && !hz;
    if (rst) exp_q.delete();
    if (acc) exp_q.push_back(expected_entry());
    model_occ = rst ? 1'b0 : flush ? 1'b0 : (model_occ && !out_ready) ? 1'b1 : acc;
    @(posedge clk);
    #1;
    if (rst) model_known = 1'b1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; in_ctl = 7'h00; in_rs = 0; in_rt = 0;
    in_use = 2'b00; in_rs_data = 16'h0; in_rt_data = 16'h0; in_rd = 0; in_wen = 0;
    fw1_wen = 0; fw1_load = 0; fw1_rd = 0; fw1_data = 16'h0;
    fw2_wen = 0; fw2_rd = 0; fw2_data = 16'h0; out_ready = 1;
  endtask

  task automatic rand_inputs(input bit allow_ctl);
    in_valid   = ($urandom_range(0, 3) != 0);
    in_ctl     = 7'($urandom);
    in_rs      = 3'($urandom_range(0, 3));
    in_rt      = 3'($urandom_range(0, 3));
    in_use     = 2'($urandom);
    in_rs_data = 16'($urandom);
    in_rt_data = 16'($urandom);
    in_rd      = 3'($urandom);
    in_wen     = 1'($urandom);
    fw1_wen    = 1'($urandom);
    fw1_load   = ($urandom_range(0, 2) == 0);
    fw1_rd     = 3'($urandom_range(0, 3));
    fw1_data   = 16'($urandom);
    fw2_wen    = 1'($urandom);
    fw2_rd     = 3'($urandom_range(0, 3));
    fw2_data   = 16'($urandom);
    if (allow_ctl) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
  endtask

  // Monitor: runs after the stimulus has updated the scoreboard for this cycle.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #1;
      if (model_known && !rst) begin
        if (!out_valid) check("idle_wen_err", 64'({out_wen, out_err}), 64'(0));
        if (out_valid && (out_ready || flush)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_entry", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            if (!flush)
              check("entry", 64'({out_A, out_B, out_ctl, out_rd, out_wen, out_err}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    entry_t held;
    idle();
    // Two reset cycles with an instruction presented.
    rst = 1; in_valid = 1; in_use = 2'b11; in_ctl = 7'h55; in_rd = 3'd5; in_wen = 1;
    in_rs_data = 16'hAAAA; in_rt_data = 16'h5555;
    step();
    check("rst_state", 64'({out_valid, out_A, out_B, out_ctl, out_rd, out_wen, out_err, in_ready}), 64'(0));
    step();
    idle();

    // Forwarding priority on operand A.
    in_valid = 1; in_rs = 3; in_use = 2'b10; in_rs_data = 16'h3333;
    fw1_wen = 1; fw1_rd = 3; fw1_data = 16'h1111;
    fw2_wen = 1; fw2_rd = 3; fw2_data = 16'h2222;
    step();
    check("fwd_fw1", 64'(out_A), 64'(16'h1111));
    fw1_wen = 0;
    step();
    check("fwd_fw2", 64'(out_A), 64'(16'h2222));
    fw2_wen = 0;
    step();
    check("fwd_rf", 64'(out_A), 64'(16'h3333));

    // Load-use stall on operand B, then resolved through MEM/WB.
    in_rt = 2; in_use = 2'b01; in_rt_data = 16'h0BAD;
    fw1_wen = 1; fw1_load = 1; fw1_rd = 2;
    step();
    check("load_use_bubble", 64'(out_valid), 64'(0));
    fw1_wen = 0; fw1_load = 0; fw2_wen = 1; fw2_rd = 2; fw2_data = 16'hBEEF;
    step();
    check("load_use_fwd", 64'({out_valid, out_B}), 64'({1'b1, 16'hBEEF}));

    // Hold for three cycles with changing inputs, then release.
    held = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      rand_inputs(1'b0);
      in_valid = 1; out_ready = 0; flush = 0; rst = 0;
      step();
      check("hold_stable", 64'({out_A, out_B, out_ctl, out_rd, out_wen, out_err}), 64'(held));
    end
    out_ready = 1; fw1_load = 0;
    step();
    check("release_capture", 64'(out_valid), 64'(1));

    // Flush during hold drops the held entry and the presented one.
    out_ready = 0; in_valid = 1;
    step();
    flush = 1;
    step();
    check("flush_drop", 64'(out_valid), 64'(0));
    flush = 0;

    // Illegal-op flag boundary.
    idle();
    in_valid = 1; in_ctl = {4'b1001, 3'b010};
    step();
    check("err_op9", 64'({out_valid, out_err}), 64'({1'b1, 1'b1}));
    in_ctl = {4'b1000, 3'b101};
    step();
    check("err_op8", 64'({out_valid, out_err}), 64'({1'b1, 1'b0}));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs(1'b1);
      step();
    end

    // Drain and confirm nothing is left outstanding.
    idle();
    for (int i = 0; i < 4; i++) step();
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 No parameters; datapath fixed at 16 bits, register specifiers 3 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discard held and incoming instruction (branch/exception redirect).
REQ-005 in_valid  input  1  decode side presents an instruction.
REQ-006 in_ready  output  1  stage accepts the presented instruction this cycle.
REQ-007 in_ctl  input  7  {op[3:0], invA, invB, sign} ALU control from decode.
REQ-008 in_rs  input  3  source-A register number.
REQ-009 in_rt  input  3  source-B register number.
REQ-010 in_use  input  2  [1] source A reads rs, [0] source B reads rt (0 = immediate already in in_rt_data).
REQ-011 in_rs_data  input  16  register-file value for rs.
REQ-012 in_rt_data  input  16  register-file value for rt, or immediate.
REQ-013 in_rd  input  3  destination register number.
REQ-014 in_wen  input  1  instruction writes in_rd.
REQ-015 fw1_wen  input  1  EX/MEM instruction writes a register.
REQ-016 fw1_load  input  1  EX/MEM instruction is a load (data not yet available).
REQ-017 fw1_rd  input  3  EX/MEM destination.
REQ-018 fw1_data  input  16  EX/MEM ALU result.
REQ-019 fw2_wen  input  1  MEM/WB instruction writes a register.
REQ-020 fw2_rd  input  3  MEM/WB destination.
REQ-021 fw2_data  input  16  MEM/WB writeback value.
REQ-022 out_valid  output  1  registered ALU operands/control are valid.
REQ-023 out_ready  input  1  ALU stage consumes the held entry this cycle.
REQ-024 out_A  output  16  registered ALU operand A.
REQ-025 out_B  output  16  registered ALU operand B.
REQ-026 out_ctl  output  7  registered {Op, invA, invB, sign} to the ALU.
REQ-027 out_rd  output  3  registered destination.
REQ-028 out_wen  output  1  registered write enable; 0 whenever out_valid=0.
REQ-029 out_err  output  1  registered illegal-op flag (op > 4'b1000); 0 whenever out_valid=0.

Function
REQ-030 Hazard (comb.) = in_valid & fw1_wen & fw1_load & ((in_use[1] & in_rs==fw1_rd) | (in_use[0] & in_rt==fw1_rd)).
REQ-031 Operand select per source: fw1 match (fw1_wen & ~fw1_load & rd equal) > fw2 match (fw2_wen & rd equal) > register-file value; applied only when matching in_use bit set, else raw in_*_data; no special case for R0.
REQ-032 in_ready = ~rst & (flush | ((~out_valid | out_ready) & ~hazard)).
REQ-033 Priority each edge: rst > flush > advance > hold.
REQ-034 Flush: out_valid<=0, out_wen<=0, out_err<=0; presented input dropped.
REQ-035 Advance (out_valid=0 or out_ready=1): if in_valid & ~hazard, capture selected operands, in_ctl, in_rd, in_wen, err flag, out_valid<=1; else insert bubble (out_valid<=0, out_wen<=0, out_err<=0).
REQ-036 Hold (out_valid=1, out_ready=0): all outputs stable; no re-forwarding of held operands.
REQ-037 Latency: accepted instruction appears on outputs exactly 1 cycle later; load-use costs exactly 1 bubble once fw1 advances.
REQ-038 Simultaneous out_ready and new capture in same cycle = full throughput, no bubble.

Reset
REQ-039 rst: out_valid, out_wen, out_err=0; out_A, out_B=16'h0000; out_ctl=7'h00; out_rd=3'b000; in_ready=0 while rst high; mid-stall reset drops held entry.

Verification
REQ-040 rst=1 two cycles, in_valid=1 -> in_ready=0, out_valid=0, all outputs zero after first edge.
REQ-041 in_rs=3, in_use=10, fw1 rd=3 data 16'h1111, fw2 rd=3 data 16'h2222, rs_data 16'h3333 -> out_A=16'h1111; repeat with fw1_wen=0 -> 16'h2222; both off -> 16'h3333.
REQ-042 fw1_load=1, fw1_rd=2, in_rt=2, in_use=01 -> in_ready=0, next out_valid=0; next cycle fw1_wen=0, fw2 rd=2 data 16'hBEEF -> out_B=16'hBEEF, out_valid=1.
REQ-043 out_valid=1, out_ready=0 for 3 cycles with changing inputs -> outputs constant, in_ready=0; out_ready=1 -> new entry captured next edge.
REQ-044 flush=1 during hold with in_valid=1 -> in_ready=1, next out_valid=0, input not captured.
REQ-045 in_ctl op=4'b1001 -> out_err=1, out_valid=1; op=4'b1000 -> out_err=0.
